// File: rtl/sky130_sram_1rw1r_param.sv
// Parametrised single-clock 1RW1R SRAM behavioural model with a post-reset clear,
// a registered read pipeline with valid flags, and read-during-write collision handling.
module sky130_sram_1rw1r_param #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           WMASK_WIDTH  = 4,
  parameter int unsigned           READ_LATENCY = 1,
  parameter int unsigned           BYPASS       = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  parameter int unsigned           CNT_WIDTH    = 8
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dout0_valid,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   init_busy,
  output logic [CNT_WIDTH-1:0]   collision_cnt
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LANE_W    = DATA_WIDTH / WMASK_WIDTH;
  localparam int unsigned PTR_W     = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAM_DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  ready, wr0, rd0, rd1, coll;
  logic [DATA_WIDTH-1:0] old0, merged0, rd1_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Index 0 is port 0, index 1 is port 1 throughout the read pipeline.
  logic [1:0]                 s1_v_q, s1_v_d;
  logic [1:0][DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [1:0]                 out_v;
  logic [1:0][DATA_WIDTH-1:0] out_data;
  logic [1:0]                 dout_v_q, dout_v_d;
  logic [1:0][DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

  assign ready = (state_q == READY);
  assign wr0   = ready && !csb0 && !web0;
  assign rd0   = ready && !csb0 && web0;
  assign rd1   = ready && !csb1;
  assign coll  = wr0 && rd1 && (addr0 == addr1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == PTR_LAST) state_d = READY;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The merged write word doubles as the bypass value for a colliding port-1 read.
  always_comb begin
    old0    = mem_q[addr0];
    merged0 = old0;
    for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
      if (wmask0[i]) merged0[i*LANE_W +: LANE_W] = din0[i*LANE_W +: LANE_W];
    end
    rd1_word  = (coll && (BYPASS != 0)) ? merged0 : mem_q[addr1];
    mem_we    = 1'b0;
    mem_waddr = addr0;
    mem_wdata = merged0;
    if (!ready) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q[ADDR_WIDTH-1:0];
      mem_wdata = INIT_VALUE;
    end else if (wr0) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    s1_v_d    = {rd1, rd0};
    s1_data_d = s1_data_q;
    if (rd0) s1_data_d[0] = old0;
    if (rd1) s1_data_d[1] = rd1_word;
    cnt_d = cnt_q;
    if (coll && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]                 s2_v_q;
      logic [1:0][DATA_WIDTH-1:0] s2_data_q;
      always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
          s2_v_q    <= '0;
          s2_data_q <= '0;
        end else begin
          s2_v_q    <= s1_v_q;
          s2_data_q <= s1_data_q;
        end
      end
      assign out_v    = s2_v_q;
      assign out_data = s2_data_q;
    end else begin : g_lat1
      assign out_v    = s1_v_q;
      assign out_data = s1_data_q;
    end
  endgenerate

  always_comb begin
    dout_d   = dout_q;
    dout_v_d = out_v;
    for (int unsigned p = 0; p < 2; p++) begin
      if (out_v[p]) dout_d[p] = out_data[p];
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      s1_v_q    <= '0;
      s1_data_q <= '0;
      dout_v_q  <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      dout_v_q  <= dout_v_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dout0         = dout_q[0];
  assign dout1         = dout_q[1];
  assign dout0_valid   = dout_v_q[0];
  assign dout1_valid   = dout_v_q[1];
  assign init_busy     = !ready;
  assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Scoreboard bench: two instances (latency 1/bypass/8-bit counter and latency 2/no bypass/
// 2-bit counter) share one stimulus stream and are checked against an array-based model.
module tb_sky130_sram_1rw1r_param;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst0, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic        a_v0, a_v1, b_v0, b_v1, a_busy, b_busy;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  sky130_sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .READ_LATENCY(1),
    .BYPASS(1), .INIT_VALUE(32'h0), .CNT_WIDTH(8)
  ) dut_a (
    .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(a_dout0), .dout0_valid(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dout1_valid(a_v1),
    .init_busy(a_busy), .collision_cnt(a_cnt)
  );

  sky130_sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .READ_LATENCY(2),
    .BYPASS(0), .INIT_VALUE(32'h0), .CNT_WIDTH(2)
  ) dut_b (
    .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_dout0), .dout0_valid(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dout1_valid(b_v1),
    .init_busy(b_busy), .collision_cnt(b_cnt)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  // Queues: 0 = A port0, 1 = A port1, 2 = B port0, 3 = B port1
  exp_t        sb[4][$];
  logic [31:0] last[4];
  logic [31:0] mem_m[DEPTH];
  string       pname[4] = '{"a_dout0", "a_dout1", "b_dout0", "b_dout1"};
  int          clear_cnt = 0;
  int          cyc = 0;
  int          col_a = 0, col_b = 0;
  int          n_tests = 0, n_fail = 0;
  bit          done = 1'b0;

  logic [3:0]  m_v;
  logic [31:0] m_d[4];
  exp_t        m_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      sb[p].delete();
      last[p] = '0;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    col_a     = 0;
    col_b     = 0;
    clear_cnt = 0;
  endtask

  // Applies the effect of the edge that just sampled the current inputs.
  task automatic model_edge();
    logic [31:0] old0, new0, d1;
    bit          wr, coll;
    if (rst0) return;
    if (clear_cnt < DEPTH) begin
      clear_cnt++;
      return;
    end
    old0 = mem_m[addr0];
    new0 = old0;
    wr   = !csb0 && !web0;
    coll = wr && !csb1 && (addr1 == addr0);
    for (int l = 0; l < 4; l++) if (wmask0[l]) new0[l*8 +: 8] = din0[l*8 +: 8];
    if (!csb0 && web0) begin
      sb[0].push_back('{old0, cyc + 1});
      sb[2].push_back('{old0, cyc + 2});
    end
    if (!csb1) begin
      d1 = mem_m[addr1];
      sb[1].push_back('{coll ? new0 : d1, cyc + 1});
      sb[3].push_back('{d1, cyc + 2});
    end
    if (coll) begin
      col_a = (col_a < 255) ? col_a + 1 : 255;
      col_b = (col_b < 3) ? col_b + 1 : 3;
    end
    if (wr) mem_m[addr0] = new0;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [3:0] m,
                       input logic [7:0] a0, input logic [31:0] d,
                       input logic c1, input logic [7:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    tick();
    idle();
  endtask

  task automatic release_and_clear(input bit poke);
    int n = 0;
    rst0 = 1'b0;
    clear_cnt = 0;
    for (int i = 0; i < 300 && a_busy; i++) begin
      if (poke && i == 4) begin
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'h10; din0 = 32'hDEADBEEF;
      end
      if (poke && i == 6) begin
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10; csb1 = 1'b0; addr1 = 8'h10;
      end
      tick();
      idle();
      n++;
    end
    chk("clear_cycles", n, DEPTH);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      m_v  = {b_v1, b_v0, a_v1, a_v0};
      m_d[0] = a_dout0; m_d[1] = a_dout1; m_d[2] = b_dout0; m_d[3] = b_dout1;
      for (int p = 0; p < 4; p++) begin
        if (sb[p].size() > 0 && sb[p][0].cyc < cyc) begin
          m_e = sb[p].pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL %s_missing_valid: no pulse, expected %h at cycle %0d", pname[p], m_e.data, m_e.cyc);
        end
        if (m_v[p]) begin
          if (sb[p].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unexpected_valid: got %h, expected no pulse (cycle %0d)", pname[p], m_d[p], cyc);
          end else begin
            m_e = sb[p].pop_front();
            chk({pname[p], "_data"}, m_d[p], m_e.data);
            chk({pname[p], "_latency"}, cyc, m_e.cyc);
            last[p] = m_e.data;
          end
        end else begin
          chk({pname[p], "_hold"}, m_d[p], last[p]);
        end
      end
      chk("a_init_busy", {31'b0, a_busy}, {31'b0, clear_cnt < DEPTH});
      chk("b_init_busy", {31'b0, b_busy}, {31'b0, clear_cnt < DEPTH});
      chk("a_collision_cnt", {24'b0, a_cnt}, col_a);
      chk("b_collision_cnt", {30'b0, b_cnt}, col_b);
    end
  end

  initial begin
    logic [7:0] ra;
    rst0 = 1'b1;
    idle();
    model_reset();
    repeat (3) tick();
    release_and_clear(1'b1);

    // Cleared contents, including the address written while clearing.
    drive(1'b0, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h7F);
    drive(1'b0, 1'b1, 4'h0, 8'hFF, 32'h0, 1'b0, 8'h10);
    drive(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00);
    repeat (3) tick();

    // Masked writes then a read on both ports.
    drive(1'b0, 1'b0, 4'hF, 8'h20, 32'h11223344, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 4'h5, 8'h20, 32'hAABBCCDD, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 4'h0, 8'h20, 32'h0, 1'b0, 8'h20);
    tick();
    chk("masked_word_lat1", a_dout0, 32'h11BB33DD);
    tick();
    chk("masked_word_lat2", b_dout0, 32'h11BB33DD);
    repeat (2) tick();

    // Same-edge write/read collision.
    drive(1'b0, 1'b0, 4'hC, 8'h30, 32'hCAFEF00D, 1'b0, 8'h30);
    chk("coll_cnt_first", {24'b0, a_cnt}, 32'd1);
    tick();
    chk("bypass_data", a_dout1, 32'hCAFE0000);
    tick();
    chk("no_bypass_valid", {31'b0, b_v1}, 32'd1);
    chk("no_bypass_data", b_dout1, 32'h00000000);

    for (int i = 0; i < 5; i++) begin
      ra = 8'h40 + 8'(i);
      drive(1'b0, 1'b0, (i == 0) ? 4'h0 : 4'($urandom), ra, $urandom, 1'b0, ra);
    end
    chk("sat_cnt_2bit", {30'b0, b_cnt}, 32'd3);
    chk("cnt_8bit", {24'b0, a_cnt}, 32'd6);

    // Back-to-back reads on both ports.
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 4'h0, 8'h1C + 8'(i), 32'h0, 1'b0, 8'h20 - 8'(i));
    repeat (3) tick();

    for (int i = 0; i < 1500; i++) begin
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = $urandom_range(0, 1);
      wmask0 = 4'($urandom);
      addr0  = 8'($urandom_range(0, 15));
      din0   = $urandom;
      csb1   = ($urandom_range(0, 3) == 0);
      addr1  = $urandom_range(0, 1) ? addr0 : 8'($urandom_range(0, 15));
      tick();
    end
    idle();
    repeat (4) tick();

    // Reset between the read-sample edge and the output edge.
    drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h05);
    rst0 = 1'b1;
    model_reset();
    #1;
    chk("rst_dout1", a_dout1, 32'h0);
    chk("rst_dout1_valid", {31'b0, a_v1}, 32'd0);
    chk("rst_init_busy", {31'b0, a_busy}, 32'd1);
    repeat (2) tick();
    release_and_clear(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4'h0, 8'(i), 32'h0, 1'b0, 8'h20);
    repeat (4) tick();

    done = 1'b1;
    for (int p = 0; p < 4; p++) chk({pname[p], "_drain"}, sb[p].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sky130_sram_1rw1r_param.md
Name: sky130_sram_1rw1r_param

Overview:
- Parametrised single-clock 1RW1R SRAM behavioural model; next generation of the team's fixed 32x256 1RW1R macro models.
- Adds configurable width, depth and mask granularity; selectable read latency; deterministic held outputs with valid flags; hardware clear after reset; defined read-during-write collision handling; a collision counter.
- Drop-in storage for Caravel-style user-project designs and for verifying controllers that will later bind to hard macros.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of WMASK_WIDTH
ADDR_WIDTH, 8, address bits; RAM_DEPTH = 1 << ADDR_WIDTH
WMASK_WIDTH, 4, write-mask lanes; lane width = DATA_WIDTH/WMASK_WIDTH
READ_LATENCY, 1, clock edges from read sample to dout update; legal values 1 or 2
BYPASS, 1, 1 = port-1 read colliding with a port-0 write returns merged new data; 0 = returns old data
INIT_VALUE, 0, DATA_WIDTH-bit word written to every location by the post-reset clear
CNT_WIDTH, 8, width of the collision counter

Ports:
clk0  input  1  single clock for both ports; all sampling on posedge
rst0  input  1  asynchronous active-high reset
csb0  input  1  port 0 active-low chip select
web0  input  1  port 0 active-low write enable
wmask0  input  WMASK_WIDTH  port 0 write lane enables; bit i covers lane i
addr0  input  ADDR_WIDTH  port 0 address
din0  input  DATA_WIDTH  port 0 write data
dout0  output  DATA_WIDTH  port 0 read data
dout0_valid  output  1  one-cycle pulse when dout0 is updated
csb1  input  1  port 1 active-low chip select (read only)
addr1  input  ADDR_WIDTH  port 1 address
dout1  output  DATA_WIDTH  port 1 read data
dout1_valid  output  1  one-cycle pulse when dout1 is updated
init_busy  output  1  high while the post-reset clear runs
collision_cnt  output  CNT_WIDTH  saturating count of same-address write/read collisions

Behaviour:
- Reset (async, rst0=1): dout0=0, dout1=0, dout0_valid=0, dout1_valid=0, collision_cnt=0, init_busy=1.
- Reset mid-operation discards in-flight read pipeline contents immediately; the valid flags drop asynchronously.
- Clear FSM states: CLEAR, READY.
  - Entered in CLEAR on reset; clear pointer = 0.
  - Each posedge in CLEAR writes INIT_VALUE to mem[ptr] and increments ptr.
  - After the write to RAM_DEPTH-1: go to READY; init_busy falls on that same edge.
  - Total clear time: RAM_DEPTH cycles after rst0 deasserts.
- While init_busy=1:
  - all port requests are ignored; no memory writes from port 0;
  - no valid pulses; collision_cnt does not count.
- Port 0 write (csb0=0, web0=0, READY): at posedge N, lanes with wmask0[i]=1 take din0 lane i; other lanes unchanged.
  - A write does not change dout0 and does not pulse dout0_valid.
  - Data is visible to any read sampled at N+1 or later.
- Port 0 read (csb0=0, web0=1): sampled at posedge N.
  - READ_LATENCY=1: dout0 = mem[addr0] updated at posedge N+1, dout0_valid=1 for that cycle.
  - READ_LATENCY=2: dout0 updated at N+2, with dout0_valid pulsed for that cycle.
- Port 1 read (csb1=0): same timing as port 0, on dout1/dout1_valid.
- Outputs hold their last value when idle; they never go X.
- Back-to-back reads on either port sustain one result per cycle.
- Collision: port 0 write and port 1 read sampled on the same edge with addr0==addr1.
  - BYPASS=1: dout1 = lanes with wmask0=1 from din0, remaining lanes from the old word.
  - BYPASS=0: dout1 = old word.
  - In both cases collision_cnt increments by 1, saturating at 2^CNT_WIDTH-1.
  - A write with wmask0=0 still counts as a collision.
- Port 0 read and port 1 read of the same address: both return the same stored word; not a collision.
- Addresses wrap naturally; all RAM_DEPTH locations are addressable, with no out-of-range case.
- Arithmetic: clear pointer is ADDR_WIDTH+1 bits so the terminal compare does not wrap. collision_cnt is unsigned.

Test Plan:
- Reset, then hold idle: init_busy=1 for exactly 256 cycles after rst0 falls. Reads of addrs 0x00, 0x7F and 0xFF then return 0x00000000 with one valid pulse each.
- Requests during clear: issue a write of 0xDEADBEEF to 0x10 at cycle 5 of the clear. After clear, read 0x10 -> 0x00000000. No valid pulse during clear. collision_cnt=0.
- Masked write: write 0x11223344 to 0x20 with mask 0xF. Then write 0xAABBCCDD to 0x20 with mask 0x5. Port 0 read of 0x20 -> 0x11BB33DD, one cycle after sample (latency 1), two cycles after with READ_LATENCY=2.
- Collision with bypass: mem[0x30]=0x00000000. Same edge: port 0 writes 0xCAFEF00D mask 0xC, port 1 reads 0x30. BYPASS=1 -> dout1=0xCAFE0000; BYPASS=0 -> dout1=0x00000000. collision_cnt=1.
- Counter saturation: with CNT_WIDTH=2, force 5 collisions -> collision_cnt=3.
- Reset mid-read: assert rst0 between the read-sample edge and the output edge -> dout1_valid never pulses, dout1=0, init_busy=1, and a fresh clear completes.
